neuron_state_bank: RTL and testbench

Parametrised per-neuron state store for the Izhikevich update pipeline. Holds v, u and a fired flag for NUM_NEURONS neurons, addressed by neuron tag. Has one registered read port and one write port with write-first bypass. An initialisation sweep FSM loads the resting state, V_INIT/U_INIT, into every entry after reset or on request. A fired-event counter feeds the spike statistics path.

---
 rtl/neuron_state_bank.sv | 161 ++++++++++++++++
 tb/tb_neuron_state_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_state_bank.sv
// Per-neuron state store (v, u, fired flag) for the Izhikevich update pipeline.
// One registered read port, one write-first write port, an init sweep FSM and a saturating fired counter.
module neuron_state_bank #(
  parameter int NUM_WIDTH   = 17,
  parameter int NUM_NEURONS = 16,
  parameter int TAG_BITS    = 4,
  parameter int V_INIT      = -16640,
  parameter int U_INIT      = -3328,
  parameter int CNT_BITS    = 16
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  input  logic                 init_req,
  output logic                 busy,
  input  logic                 rd_en,
  input  logic [TAG_BITS-1:0]  rd_tag,
  output logic                 rd_valid,
  output logic [NUM_WIDTH-1:0] v_out,
  output logic [NUM_WIDTH-1:0] u_out,
  output logic                 fired_out,
  input  logic                 wr_en,
  input  logic [TAG_BITS-1:0]  wr_tag,
  input  logic [NUM_WIDTH-1:0] v_new,
  input  logic [NUM_WIDTH-1:0] u_new,
  input  logic                 wr_fired,
  output logic [CNT_BITS-1:0]  fired_count,
  output logic                 state_dbg
);

  // Handshake: rd_en/wr_en are single-cycle requests with no backpressure; they are
  // accepted on any rising edge while busy=0 and dropped otherwise. rd_valid pulses
  // exactly one cycle after each accepted read.

  localparam logic [NUM_WIDTH-1:0] V_INIT_W = NUM_WIDTH'(V_INIT);
  localparam logic [NUM_WIDTH-1:0] U_INIT_W = NUM_WIDTH'(U_INIT);
  localparam logic [TAG_BITS:0]    NUM_N    = (TAG_BITS+1)'(NUM_NEURONS);
  localparam logic [TAG_BITS-1:0]  LAST_IDX = TAG_BITS'(NUM_NEURONS - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [TAG_BITS-1:0]   idx_q, idx_d;
  logic                  rd_valid_q;
  logic [NUM_WIDTH-1:0]  v_out_q, u_out_q;
  logic                  fired_out_q;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;

  logic [NUM_WIDTH-1:0]  v_mem [NUM_NEURONS];
  logic [NUM_WIDTH-1:0]  u_mem [NUM_NEURONS];
  logic                  f_mem [NUM_NEURONS];

  logic                  run;
  logic                  rd_in_range, wr_in_range;
  logic                  rd_ok, wr_ok;
  logic [NUM_WIDTH-1:0]  rd_v, rd_u;
  logic                  rd_f;

  assign run         = (state_q == ST_RUN);
  assign rd_in_range = ({1'b0, rd_tag} < NUM_N);
  assign wr_in_range = ({1'b0, wr_tag} < NUM_N);
  assign rd_ok       = run && rd_en;
  assign wr_ok       = run && wr_en && wr_in_range;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_INIT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (init_req) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
      end
    endcase
  end

  // Out-of-range reads see the resting state; same-tag writes bypass the array.
  always_comb begin
    rd_v = V_INIT_W;
    rd_u = U_INIT_W;
    rd_f = 1'b0;
    if (rd_in_range) begin
      if (wr_ok && (wr_tag == rd_tag)) begin
        rd_v = v_new;
        rd_u = u_new;
        rd_f = wr_fired;
      end else begin
        rd_v = v_mem[rd_tag];
        rd_u = u_mem[rd_tag];
        rd_f = f_mem[rd_tag];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (run && init_req) begin
      cnt_d = '0;
    end else if (wr_ok && wr_fired && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      rd_valid_q  <= 1'b0;
      v_out_q     <= '0;
      u_out_q     <= '0;
      fired_out_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_valid_q <= rd_ok;
      cnt_q      <= cnt_d;
      if (rd_ok) begin
        v_out_q     <= rd_v;
        u_out_q     <= rd_u;
        fired_out_q <= rd_f;
      end
    end
  end

  // The array has no reset; the sweep is what gives it a defined value.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      v_mem[idx_q] <= V_INIT_W;
      u_mem[idx_q] <= U_INIT_W;
      f_mem[idx_q] <= 1'b0;
    end else if (wr_ok) begin
      v_mem[wr_tag] <= v_new;
      u_mem[wr_tag] <= u_new;
      f_mem[wr_tag] <= wr_fired;
    end
  end

  assign busy        = (state_q == ST_INIT);
  assign rd_valid    = rd_valid_q;
  assign v_out       = v_out_q;
  assign u_out       = u_out_q;
  assign fired_out   = fired_out_q;
  assign fired_count = cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_neuron_state_bank.sv
// Bench for neuron_state_bank: default instance plus a 12-neuron / 2-bit-counter instance,
// table-driven vectors with a read-result scoreboard and hand sequences for sweep corners.
module tb_neuron_state_bank;

  localparam int W = 17;
  localparam logic [W-1:0] V_R = 17'h1BF00;  // -16640
  localparam logic [W-1:0] U_R = 17'h1F300;  // -3328

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic sel   = 1'b0;

  logic           init_req = 1'b0;
  logic           rd_en    = 1'b0;
  logic [3:0]     rd_tag   = '0;
  logic           wr_en    = 1'b0;
  logic [3:0]     wr_tag   = '0;
  logic [W-1:0]   v_new    = '0;
  logic [W-1:0]   u_new    = '0;
  logic           wr_fired = 1'b0;

  logic busy_a, rv_a, f_a, st_a;
  logic [W-1:0] v_a, u_a;
  logic [15:0] cnt_a;
  logic busy_b, rv_b, f_b, st_b;
  logic [W-1:0] v_b, u_b;
  logic [1:0] cnt_b;

  neuron_state_bank u_dut_a (
    .clk(clk), .asyn_reset(rst_a), .init_req(init_req), .busy(busy_a),
    .rd_en(rd_en), .rd_tag(rd_tag), .rd_valid(rv_a), .v_out(v_a), .u_out(u_a),
    .fired_out(f_a), .wr_en(wr_en), .wr_tag(wr_tag), .v_new(v_new), .u_new(u_new),
    .wr_fired(wr_fired), .fired_count(cnt_a), .state_dbg(st_a)
  );

  neuron_state_bank #(.NUM_NEURONS(12), .CNT_BITS(2)) u_dut_b (
    .clk(clk), .asyn_reset(rst_b), .init_req(init_req), .busy(busy_b),
    .rd_en(rd_en), .rd_tag(rd_tag), .rd_valid(rv_b), .v_out(v_b), .u_out(u_b),
    .fired_out(f_b), .wr_en(wr_en), .wr_tag(wr_tag), .v_new(v_new), .u_new(u_new),
    .wr_fired(wr_fired), .fired_count(cnt_b), .state_dbg(st_b)
  );

  logic busy_m, rv_m, f_m, st_m;
  logic [W-1:0] v_m, u_m;
  logic [15:0] cnt_m;
  assign busy_m = sel ? busy_b : busy_a;
  assign rv_m   = sel ? rv_b   : rv_a;
  assign f_m    = sel ? f_b    : f_a;
  assign st_m   = sel ? st_b   : st_a;
  assign v_m    = sel ? v_b    : v_a;
  assign u_m    = sel ? u_b    : u_a;
  assign cnt_m  = sel ? {14'b0, cnt_b} : cnt_a;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [2*W:0] exp_q[$];
  int           due_q[$];
  logic [2*W:0] mon_e;
  int           mon_d;

  always @(negedge clk) begin
    if (rv_m) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_unexpected", 32'(rv_m), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_d = due_q.pop_front();
        chk("rd_latency", 32'(cyc), 32'(mon_d));
        chk("v_out", 32'(v_m), 32'(mon_e[2*W:W+1]));
        chk("u_out", 32'(u_m), 32'(mon_e[W:1]));
        chk("fired_out", 32'(f_m), 32'(mon_e[0]));
      end
    end else if (exp_q.size() != 0 && due_q[0] <= cyc) begin
      chk("rd_valid_missing", 32'(rv_m), 32'd1);
      mon_e = exp_q.pop_front();
      mon_d = due_q.pop_front();
    end
  end

  // ---------------- vectors / drivers ----------------
  typedef struct {
    logic         wr;
    logic [3:0]   wtag;
    logic [W-1:0] v;
    logic [W-1:0] u;
    logic         f;
    logic         rd;
    logic [3:0]   rtag;
    logic [W-1:0] ev;
    logic [W-1:0] eu;
    logic         ef;
    logic [15:0]  ecnt;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [3:0] wt, input logic [W-1:0] v,
                              input logic [W-1:0] u, input logic f, input logic rd,
                              input logic [3:0] rt, input logic [W-1:0] ev,
                              input logic [W-1:0] eu, input logic ef, input logic [15:0] ec);
    vec_t t;
    t.wr = wr; t.wtag = wt; t.v = v; t.u = u; t.f = f;
    t.rd = rd; t.rtag = rt; t.ev = ev; t.eu = eu; t.ef = ef; t.ecnt = ec;
    return t;
  endfunction

  // Called at a negedge; returns at the following negedge with requests cleared.
  task automatic drive(input vec_t t, input string name);
    wr_en = t.wr; wr_tag = t.wtag; v_new = t.v; u_new = t.u; wr_fired = t.f;
    rd_en = t.rd; rd_tag = t.rtag;
    if (t.rd) begin
      exp_q.push_back({t.ev, t.eu, t.ef});
      due_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    chk({name, "_count"}, 32'(cnt_m), 32'(t.ecnt));
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; wr_fired = 1'b0;
  endtask

  // Counts negedges with busy high; optionally hammers the ports while the sweep runs.
  task automatic count_busy(input int exp_n, input logic poke, input string name);
    int n = 0;
    while (busy_m && n < 100) begin
      if (poke) begin
        rd_en = 1'b1; rd_tag = 4'd9; wr_en = 1'b1; wr_tag = 4'd9;
        v_new = 17'd1234; u_new = 17'd4321; wr_fired = 1'b1;
      end
      chk({name, "_rd_valid_in_sweep"}, 32'(rv_m), 32'd0);
      n++;
      @(negedge clk);
    end
    rd_en = 1'b0; wr_en = 1'b0; wr_fired = 1'b0;
    chk({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
    chk({name, "_state_run"}, 32'(st_m), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_busy"}, 32'(busy_m), 32'd1);
    chk({name, "_rd_valid"}, 32'(rv_m), 32'd0);
    chk({name, "_v"}, 32'(v_m), 32'd0);
    chk({name, "_u"}, 32'(u_m), 32'd0);
    chk({name, "_fired"}, 32'(f_m), 32'd0);
    chk({name, "_count"}, 32'(cnt_m), 32'd0);
  endtask

  vec_t va[9];
  vec_t vb[9];

  initial begin
    va[0] = mk(1, 5, 17'd1000, 17'(-200), 1, 0, 0, '0, '0, 0, 16'd1);
    va[1] = mk(0, 0, '0, '0, 0, 1, 5, 17'd1000, 17'(-200), 1, 16'd1);
    va[2] = mk(0, 0, '0, '0, 0, 1, 4, V_R, U_R, 0, 16'd1);
    va[3] = mk(1, 3, 17'd777, 17'(-50), 0, 1, 3, 17'd777, 17'(-50), 0, 16'd1);
    va[4] = mk(1, 7, 17'd5, 17'd6, 1, 1, 2, V_R, U_R, 0, 16'd2);
    va[5] = mk(0, 0, '0, '0, 0, 1, 7, 17'd5, 17'd6, 1, 16'd2);
    va[6] = mk(1, 0, 17'h10000, 17'h0FFFF, 0, 1, 0, 17'h10000, 17'h0FFFF, 0, 16'd2);
    va[7] = mk(1, 5, 17'd9, 17'd9, 0, 1, 3, 17'd777, 17'(-50), 0, 16'd2);
    va[8] = mk(0, 0, '0, '0, 0, 1, 5, 17'd9, 17'd9, 0, 16'd2);

    vb[0] = mk(1, 13, 17'd111, 17'd222, 1, 0, 0, '0, '0, 0, 16'd0);
    vb[1] = mk(0, 0, '0, '0, 0, 1, 13, V_R, U_R, 0, 16'd0);
    vb[2] = mk(1, 11, 17'd1, 17'd2, 1, 1, 13, V_R, U_R, 0, 16'd1);
    vb[3] = mk(1, 1, 17'd3, 17'd4, 1, 1, 11, 17'd1, 17'd2, 1, 16'd2);
    vb[4] = mk(1, 2, 17'd5, 17'd6, 1, 0, 0, '0, '0, 0, 16'd3);
    vb[5] = mk(1, 3, 17'd7, 17'd8, 1, 1, 1, 17'd3, 17'd4, 1, 16'd3);
    vb[6] = mk(1, 4, 17'd9, 17'd10, 1, 1, 15, V_R, U_R, 0, 16'd3);
    vb[7] = mk(1, 13, 17'd1, 17'd1, 1, 1, 13, V_R, U_R, 0, 16'd3);
    vb[8] = mk(0, 0, '0, '0, 0, 1, 4, 17'd9, 17'd10, 1, 16'd3);

    // ---- default instance ----
    sel = 1'b0;
    @(negedge clk);
    check_reset_outputs("a_reset");
    rst_a = 1'b0;
    count_busy(16, 1'b1, "a_sweep0");
    chk("a_count_after_sweep", 32'(cnt_m), 32'd0);
    for (int i = 0; i < 16; i++)
      drive(mk(0, 0, '0, '0, 0, 1, 4'(i), V_R, U_R, 0, 16'd0), $sformatf("a_rest%0d", i));
    for (int i = 0; i < 9; i++)
      drive(va[i], $sformatf("a_vec%0d", i));
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    count_busy(16, 1'b0, "a_sweep1");
    chk("a_count_after_init", 32'(cnt_m), 32'd0);
    drive(mk(0, 0, '0, '0, 0, 1, 5, V_R, U_R, 0, 16'd0), "a_reinit5");
    drive(mk(0, 0, '0, '0, 0, 1, 0, V_R, U_R, 0, 16'd0), "a_reinit0");
    @(negedge clk);
    rst_a = 1'b1;

    // ---- 12 neurons, 2-bit counter ----
    sel = 1'b1;
    @(negedge clk);
    check_reset_outputs("b_reset");
    rst_b = 1'b0;
    count_busy(12, 1'b0, "b_sweep0");
    for (int i = 0; i < 9; i++)
      drive(vb[i], $sformatf("b_vec%0d", i));
    drive(mk(0, 0, '0, '0, 0, 1, 0, V_R, U_R, 0, 16'd3), "b_pre_abort");
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_b = 1'b1;
    #1;
    check_reset_outputs("b_abort");
    @(negedge clk);
    rst_b = 1'b0;
    count_busy(12, 1'b0, "b_sweep1");
    drive(mk(0, 0, '0, '0, 0, 1, 11, V_R, U_R, 0, 16'd0), "b_after11");
    drive(mk(0, 0, '0, '0, 0, 1, 1, V_R, U_R, 0, 16'd0), "b_after1");
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
